// File: rtl/tournament_bpred.sv
// tournament_bpred: tournament branch predictor (local + gshare global + selector).
// Queried combinationally by fetch/decode, trained by the ROB at branch commit.
// Ports:
//   clk_in, rst_n_in (async active-low), rdy_in (global stall when low)
//   init_done          : table initialisation sweep finished
//   q_valid/q_addr     : prediction query; q_take/q_ghr combinational answer
//   upd_*              : commit-time training with the history snapshot
//   stat_branches/stat_mispred : saturating training statistics
module tournament_bpred #(
  parameter int IDX_BITS = 10,
  parameter int GHR_BITS = 10,
  parameter int CTR_BITS = 2,
  parameter int ADDR_LSB = 2,
  parameter int SEL_INIT = 1
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                rdy_in,
  output logic                init_done,
  input  logic                q_valid,
  input  logic [31:0]         q_addr,
  output logic                q_take,
  output logic [GHR_BITS-1:0] q_ghr,
  input  logic                upd_valid,
  input  logic [31:0]         upd_addr,
  input  logic [GHR_BITS-1:0] upd_ghr,
  input  logic                upd_take,
  input  logic                upd_mispredict,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispred
);

  localparam int ENTRIES = 1 << IDX_BITS;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;
  typedef logic [CTR_BITS-1:0] ctr_t;
  typedef logic [IDX_BITS-1:0] idx_t;

  localparam ctr_t CTR_MAX  = {CTR_BITS{1'b1}};
  localparam ctr_t CTR_ZERO = {CTR_BITS{1'b0}};
  localparam ctr_t CTR_ONE  = ctr_t'(1'b1);
  localparam ctr_t SEL_RST  = ctr_t'(SEL_INIT);
  localparam idx_t IDX_ONE  = idx_t'(1'b1);
  localparam idx_t IDX_LAST = {IDX_BITS{1'b1}};
  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

  function automatic ctr_t ctr_inc(input ctr_t c);
    return (c == CTR_MAX) ? c : c + CTR_ONE;
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    return (c == CTR_ZERO) ? c : c - CTR_ONE;
  endfunction

  function automatic logic [31:0] stat_inc(input logic [31:0] s);
    return (s == STAT_MAX) ? s : s + 32'd1;
  endfunction

  function automatic idx_t local_idx(input logic [31:0] a);
    return a[ADDR_LSB +: IDX_BITS];
  endfunction

  // History only covers the low index bits; upper bits come from the PC alone.
  function automatic idx_t global_idx(input logic [31:0] a, input logic [GHR_BITS-1:0] h);
    idx_t ext;
    ext = '0;
    ext[GHR_BITS-1:0] = h;
    return local_idx(a) ^ ext;
  endfunction

  state_e              state_q, state_d;
  idx_t                init_idx_q, init_idx_d;
  logic                init_done_q, init_done_d;
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [31:0]         stat_br_q, stat_br_d;
  logic [31:0]         stat_mp_q, stat_mp_d;

  ctr_t local_q  [ENTRIES];
  ctr_t global_q [ENTRIES];
  ctr_t sel_q    [ENTRIES];

  logic loc_we_s, glb_we_s, sel_we_s;
  idx_t loc_idx_s, glb_idx_s, sel_idx_s;
  ctr_t loc_wd_s, glb_wd_s, sel_wd_s;

  idx_t q_li_s, q_gi_s, u_li_s, u_gi_s;
  logic u_lc_s, u_gc_s;
  logic unused_ok;

  assign q_li_s = local_idx(q_addr);
  assign q_gi_s = global_idx(q_addr, ghr_q);
  assign u_li_s = local_idx(upd_addr);
  assign u_gi_s = global_idx(upd_addr, upd_ghr);
  assign u_lc_s = (local_q[u_li_s][CTR_BITS-1]  == upd_take);
  assign u_gc_s = (global_q[u_gi_s][CTR_BITS-1] == upd_take);
  assign unused_ok = ^{q_addr, upd_addr};

  assign init_done     = init_done_q;
  assign stat_branches = stat_br_q;
  assign stat_mispred  = stat_mp_q;

  // Query path: selector picks local or global prediction, forced off outside RUN.
  always_comb begin
    q_take = 1'b0;
    q_ghr  = '0;
    if (state_q == ST_RUN) begin
      q_ghr = ghr_q;
      if (sel_q[q_li_s][CTR_BITS-1]) begin
        q_take = local_q[q_li_s][CTR_BITS-1];
      end else begin
        q_take = global_q[q_gi_s][CTR_BITS-1];
      end
    end else begin
      q_take = 1'b0;
    end
  end

  // Next-state: init sweep, speculative history, training and statistics.
  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
    ghr_d       = ghr_q;
    stat_br_d   = stat_br_q;
    stat_mp_d   = stat_mp_q;
    loc_we_s    = 1'b0;
    glb_we_s    = 1'b0;
    sel_we_s    = 1'b0;
    loc_idx_s   = u_li_s;
    glb_idx_s   = u_gi_s;
    sel_idx_s   = u_li_s;
    loc_wd_s    = CTR_ZERO;
    glb_wd_s    = CTR_ZERO;
    sel_wd_s    = SEL_RST;
    if (rdy_in) begin
      case (state_q)
        ST_INIT: begin
          loc_we_s   = 1'b1;
          glb_we_s   = 1'b1;
          sel_we_s   = 1'b1;
          loc_idx_s  = init_idx_q;
          glb_idx_s  = init_idx_q;
          sel_idx_s  = init_idx_q;
          init_idx_d = init_idx_q + IDX_ONE;
          if (init_idx_q == IDX_LAST) begin
            state_d     = ST_RUN;
            init_done_d = 1'b1;
          end else begin
            state_d     = ST_INIT;
          end
        end
        ST_RUN: begin
          if (q_valid) begin
            ghr_d = {ghr_q[GHR_BITS-2:0], q_take};
          end else begin
            ghr_d = ghr_q;
          end
          if (upd_valid) begin
            loc_we_s  = 1'b1;
            glb_we_s  = 1'b1;
            sel_we_s  = 1'b1;
            loc_wd_s  = upd_take ? ctr_inc(local_q[u_li_s])  : ctr_dec(local_q[u_li_s]);
            glb_wd_s  = upd_take ? ctr_inc(global_q[u_gi_s]) : ctr_dec(global_q[u_gi_s]);
            // Selector moves toward whichever component alone was correct.
            if (u_gc_s && !u_lc_s) begin
              sel_wd_s = ctr_dec(sel_q[u_li_s]);
            end else if (!u_gc_s && u_lc_s) begin
              sel_wd_s = ctr_inc(sel_q[u_li_s]);
            end else begin
              sel_wd_s = sel_q[u_li_s];
            end
            stat_br_d = stat_inc(stat_br_q);
            if (upd_mispredict) begin
              stat_mp_d = stat_inc(stat_mp_q);
              // Recovery overrides any same-cycle speculative shift.
              ghr_d     = {upd_ghr[GHR_BITS-2:0], upd_take};
            end else begin
              stat_mp_d = stat_mp_q;
            end
          end else begin
            stat_br_d = stat_br_q;
          end
        end
        default: begin
          state_d = ST_INIT;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Control and statistics registers with asynchronous reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_INIT;
      init_idx_q  <= '0;
      init_done_q <= 1'b0;
      ghr_q       <= '0;
      stat_br_q   <= 32'd0;
      stat_mp_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
      ghr_q       <= ghr_d;
      stat_br_q   <= stat_br_d;
      stat_mp_q   <= stat_mp_d;
    end
  end

  // Prediction tables; contents are established by the init sweep, not reset.
  always_ff @(posedge clk_in) begin
    if (loc_we_s) local_q[loc_idx_s]  <= loc_wd_s;
    if (glb_we_s) global_q[glb_idx_s] <= glb_wd_s;
    if (sel_we_s) sel_q[sel_idx_s]    <= sel_wd_s;
  end

endmodule

// File: tb/tb_tournament_bpred.sv
module tb_tournament_bpred;

  localparam int IDX = 4;
  localparam int GHR = 4;
  localparam int N   = 16;
  localparam int CMAX = 3;
  localparam int THR  = 2;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        init_done;
  logic        q_valid;
  logic [31:0] q_addr;
  logic        q_take;
  logic [3:0]  q_ghr;
  logic        upd_valid;
  logic [31:0] upd_addr;
  logic [3:0]  upd_ghr;
  logic        upd_take;
  logic        upd_mispredict;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  int checks = 0;
  int errors = 0;

  // reference model state
  int     m_loc [N];
  int     m_glb [N];
  int     m_sel [N];
  int     m_ghr;
  bit     m_run;
  int     m_init;
  longint m_br;
  longint m_mp;

  tournament_bpred #(.IDX_BITS(IDX), .GHR_BITS(GHR), .CTR_BITS(2), .ADDR_LSB(2), .SEL_INIT(1)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .init_done(init_done),
    .q_valid(q_valid), .q_addr(q_addr), .q_take(q_take), .q_ghr(q_ghr),
    .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_ghr(upd_ghr), .upd_take(upd_take),
    .upd_mispredict(upd_mispredict), .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pc_index(input logic [31:0] a);
    return int'((a >> 2) % N);
  endfunction

  function automatic bit model_take(input logic [31:0] a);
    int i;
    int g;
    if (!m_run) return 1'b0;
    i = pc_index(a);
    g = i ^ m_ghr;
    if (m_sel[i] >= THR) return (m_loc[i] >= THR);
    return (m_glb[g] >= THR);
  endfunction

  function automatic int bump(input int v, input bit up);
    if (up) return (v < CMAX) ? v + 1 : v;
    return (v > 0) ? v - 1 : v;
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_init = 0; m_ghr = 0; m_br = 0; m_mp = 0;
  endtask

  task automatic model_update(input bit qt);
    int i, g, nghr;
    bit lc, gc;
    if (!rdy_in) return;
    if (!m_run) begin
      m_loc[m_init] = 0; m_glb[m_init] = 0; m_sel[m_init] = 1;
      m_init++;
      if (m_init == N) begin m_run = 1'b1; m_init = 0; end
      return;
    end
    nghr = m_ghr;
    if (q_valid) nghr = (m_ghr * 2 + int'(qt)) % N;
    if (upd_valid) begin
      i  = pc_index(upd_addr);
      g  = i ^ int'(upd_ghr);
      lc = ((m_loc[i] >= THR) == upd_take);
      gc = ((m_glb[g] >= THR) == upd_take);
      m_loc[i] = bump(m_loc[i], upd_take);
      m_glb[g] = bump(m_glb[g], upd_take);
      if (gc && !lc) m_sel[i] = bump(m_sel[i], 1'b0);
      else if (!gc && lc) m_sel[i] = bump(m_sel[i], 1'b1);
      if (m_br < 64'hFFFF_FFFF) m_br++;
      if (upd_mispredict) begin
        if (m_mp < 64'hFFFF_FFFF) m_mp++;
        nghr = (int'(upd_ghr) * 2 + int'(upd_take)) % N;
      end
    end
    m_ghr = nghr;
  endtask

  task automatic compare_all();
    check("q_take",        {31'd0, q_take},    {31'd0, model_take(q_addr)});
    check("q_ghr",         {28'd0, q_ghr},     m_run ? m_ghr : 0);
    check("init_done",     {31'd0, init_done}, {31'd0, m_run});
    check("stat_branches", stat_branches,      m_br[31:0]);
    check("stat_mispred",  stat_mispred,       m_mp[31:0]);
  endtask

  // one clock: compare mid-low-phase, advance model at the edge, return at negedge
  task automatic step();
    bit qt;
    #1;
    compare_all();
    qt = model_take(q_addr);
    @(posedge clk_in);
    model_update(qt);
    @(negedge clk_in);
  endtask

  task automatic randomize_inputs(input int rdy_mod);
    rdy_in         = ($urandom % rdy_mod) != 0;
    q_valid        = $urandom % 2;
    q_addr         = $urandom;
    upd_valid      = $urandom % 2;
    upd_addr       = $urandom;
    upd_ghr        = 4'($urandom);
    upd_take       = $urandom % 2;
    upd_mispredict = ($urandom % 4) == 0;
  endtask

  initial begin
    logic [31:0] save_br, save_mp;
    int save_ghr;
    int budget;
    rst_n_in = 1'b0; rdy_in = 1'b1;
    q_valid = 1'b0; q_addr = 32'd0;
    upd_valid = 1'b0; upd_addr = 32'd0; upd_ghr = 4'd0; upd_take = 1'b0; upd_mispredict = 1'b0;
    model_reset();

    @(negedge clk_in);
    #1;
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_stat_br",   stat_branches, 32'd0);
    check("rst_q_ghr",     {28'd0, q_ghr}, 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // init sweep with a query that must be ignored
    q_valid = 1'b1; q_addr = 32'h40;
    for (int k = 0; k < N; k++) begin
      if (k == N - 1) begin
        #1;
        check("init_not_done_15", {31'd0, init_done}, 32'd0);
        check("init_q_take", {31'd0, q_take}, 32'd0);
      end
      step();
    end
    #1;
    check("init_done_16", {31'd0, init_done}, 32'd1);
    check("init_ghr_held", {28'd0, q_ghr}, 32'd0);
    q_valid = 1'b0;

    // train 0x100 taken twice with history 0
    upd_valid = 1'b1; upd_addr = 32'h100; upd_ghr = 4'd0; upd_take = 1'b1; upd_mispredict = 1'b0;
    step(); step();
    upd_valid = 1'b0;
    #1;
    check("stat_br_two", stat_branches, 32'd2);
    q_valid = 1'b1; q_addr = 32'h100;
    #1;
    check("q_take_trained", {31'd0, q_take}, 32'd1);
    q_valid = 1'b0;
    upd_valid = 1'b1;
    upd_ghr = 4'd1; step(); step();
    upd_ghr = 4'd3; step(); step();
    upd_valid = 1'b0;

    // speculative history 0,1,3 then mispredict recovery
    q_valid = 1'b1; q_addr = 32'h100;
    #1; check("ghr_0", {28'd0, q_ghr}, 32'd0); check("take_0", {31'd0, q_take}, 32'd1);
    step();
    #1; check("ghr_1", {28'd0, q_ghr}, 32'd1); check("take_1", {31'd0, q_take}, 32'd1);
    step();
    #1; check("ghr_3", {28'd0, q_ghr}, 32'd3); check("take_3", {31'd0, q_take}, 32'd1);
    upd_valid = 1'b1; upd_addr = 32'h104; upd_ghr = 4'h5; upd_take = 1'b0; upd_mispredict = 1'b1;
    step();
    q_valid = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
    #1;
    check("ghr_recover", {28'd0, q_ghr}, 32'hA);
    check("stat_mp_one", stat_mispred, 32'd1);

    // alternating outcomes at 0x200, global entries chosen to track them
    upd_valid = 1'b1; upd_addr = 32'h200;
    for (int k = 0; k < 10; k++) begin
      upd_take = k[0];
      upd_ghr  = upd_take ? 4'd1 : 4'd2;
      q_valid = 1'b1; q_addr = 32'h200;
      step();
    end
    upd_valid = 1'b0; q_valid = 1'b0;

    // stall: nothing may change
    save_br = m_br[31:0]; save_mp = m_mp[31:0]; save_ghr = m_ghr;
    rdy_in = 1'b0; q_valid = 1'b1; upd_valid = 1'b1; upd_mispredict = 1'b1;
    for (int k = 0; k < 5; k++) step();
    #1;
    check("stall_br",  stat_branches, save_br);
    check("stall_mp",  stat_mispred, save_mp);
    check("stall_ghr", {28'd0, q_ghr}, save_ghr);
    rdy_in = 1'b1; q_valid = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;

    // randomized run, addresses folded onto a few lines to exercise aliasing
    for (int k = 0; k < 3000; k++) begin
      randomize_inputs(8);
      if (k % 2 == 0) q_addr = q_addr & 32'h0000_007C;
      if (k % 3 == 0) upd_addr = upd_addr & 32'h0000_007C;
      step();
    end

    // asynchronous reset between edges
    #2;
    rst_n_in = 1'b0;
    model_reset();
    #1;
    check("arst_init_done", {31'd0, init_done}, 32'd0);
    check("arst_stat_br",   stat_branches, 32'd0);
    check("arst_stat_mp",   stat_mispred, 32'd0);
    check("arst_q_ghr",     {28'd0, q_ghr}, 32'd0);
    check("arst_q_take",    {31'd0, q_take}, 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // re-init sweep with random stalls, bounded
    budget = 0;
    while (!m_run && budget < 200) begin
      randomize_inputs(3);
      step();
      budget++;
    end
    check("reinit_in_budget", {31'd0, m_run}, 32'd1);
    for (int k = 0; k < 800; k++) begin
      randomize_inputs(6);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
